// File: rtl/registro_4_secuenciador.sv
// Command sequencer for a 4-bit shift register: accepts one command over valid/ready,
// drives ENB/MODO/DIR/S_IN/D for the exact step count, and returns the final Q.
module registro_4_secuenciador #(
  parameter int CNT_W = 4,
  parameter int CAP_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [3:0]       CMD_DATA,
  input  logic [CAP_W-1:0] CMD_SDATA,
  output logic             REG_ENB,
  output logic [1:0]       REG_MODO,
  output logic             REG_DIR,
  output logic             REG_S_IN,
  output logic [3:0]       REG_D,
  input  logic [3:0]       REG_Q,
  input  logic             REG_S_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       RES_Q,
  output logic [CAP_W-1:0] RES_CAP
);
  localparam logic [1:0] OP_SHIFT  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;
  localparam logic [1:0] MODO_HOLD = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic [3:0]       data;
    logic [CAP_W-1:0] sdata;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd, cmd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, last_idx, nxt_idx;
  logic             accept, go_exec, last_step, s_bit;

  logic             ready_nxt, busy_nxt, done_nxt, enb_nxt, dir_nxt, s_in_nxt;
  logic [1:0]       modo_nxt;
  logic [3:0]       d_nxt, q_nxt;
  logic [CAP_W-1:0] cap_nxt;

  assign accept    = (state == IDLE) && CMD_VALID && CMD_READY;
  assign go_exec   = (CMD_OP == OP_LOAD) || ((CMD_OP != OP_READ) && (CMD_COUNT != '0));
  assign last_idx  = cmd.count - 1'b1;
  assign nxt_idx   = cnt + 1'b1;
  assign last_step = (cmd.op == OP_LOAD) || (cnt == last_idx);
  // S_IN is registered, so the bit for the following step is picked one cycle ahead
  assign s_bit     = |(cmd.sdata & (CAP_W'(1) << nxt_idx));

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      CMD_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      REG_ENB   <= 1'b0;
      REG_MODO  <= MODO_HOLD;
      REG_DIR   <= 1'b0;
      REG_S_IN  <= 1'b0;
      REG_D     <= '0;
      RES_Q     <= '0;
      RES_CAP   <= '0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      cnt       <= cnt_nxt;
      CMD_READY <= ready_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      REG_ENB   <= enb_nxt;
      REG_MODO  <= modo_nxt;
      REG_DIR   <= dir_nxt;
      REG_S_IN  <= s_in_nxt;
      REG_D     <= d_nxt;
      RES_Q     <= q_nxt;
      RES_CAP   <= cap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_exec ? EXEC : FIN;
      EXEC:    if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_nxt   = cmd;
    cnt_nxt   = cnt;
    ready_nxt = CMD_READY;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    enb_nxt   = REG_ENB;
    modo_nxt  = REG_MODO;
    dir_nxt   = REG_DIR;
    s_in_nxt  = REG_S_IN;
    d_nxt     = REG_D;
    q_nxt     = RES_Q;
    cap_nxt   = RES_CAP;
    case (state)
      IDLE: if (accept) begin
        cmd_nxt   = '{op: CMD_OP, dir: CMD_DIR, count: CMD_COUNT, data: CMD_DATA, sdata: CMD_SDATA};
        cnt_nxt   = '0;
        cap_nxt   = '0;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b1;
        if (go_exec) begin
          enb_nxt  = 1'b1;
          modo_nxt = CMD_OP;
          dir_nxt  = CMD_DIR;
          d_nxt    = CMD_DATA;
          s_in_nxt = (CMD_OP == OP_SHIFT) ? CMD_SDATA[0] : 1'b0;
        end
      end
      EXEC: begin
        cnt_nxt = nxt_idx;
        if (cmd.op == OP_SHIFT) cap_nxt = {RES_CAP[CAP_W-2:0], REG_S_OUT};
        if (last_step) begin
          enb_nxt  = 1'b0;
          modo_nxt = MODO_HOLD;
          s_in_nxt = 1'b0;
        end else begin
          s_in_nxt = (cmd.op == OP_SHIFT) ? s_bit : 1'b0;
        end
      end
      FIN: begin
        q_nxt     = REG_Q;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
